// File: rtl/mult_pkg.sv
// Shared definitions for the arbitrated multiplier: FSM states, default operand
// width and the round-robin pointer increment.
package mult_pkg;

    localparam int DEFAULT_TAM = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN,
        ST_ABORT
    } state_t;

    // Next round-robin start index after serving requester idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mult_rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr,
// wrapping modulo NREQ, reported as one-hot and as an index.
module mult_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [NREQ-1:0] winner_oh,
    output logic [IW-1:0]   winner_idx
);
    int idx;

    // Scan requesters starting at the pointer and keep the first one found.
    always_comb begin
        any        = 1'b0;
        winner_oh  = '0;
        winner_idx = '0;
        idx        = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!any && req[idx]) begin
                any            = 1'b1;
                winner_oh[idx] = 1'b1;
                winner_idx     = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/multipli.sv
// Sequential signed multiplier: operands are captured on start, the product
// appears TAM cycles later and end_mult stays high for two cycles.
module multipli #(
    parameter int TAM = 8
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               start,
    input  logic [TAM-1:0]     a,
    input  logic [TAM-1:0]     b,
    output logic [2*TAM-1:0]   s,
    output logic               end_mult
);
    localparam int CW = $clog2(TAM + 1);

    logic [CW-1:0]            busy_cnt;
    logic [1:0]               end_cnt;
    logic signed [2*TAM-1:0]  a_ext;
    logic signed [2*TAM-1:0]  b_ext;

    // Capture sign-extended operands, count down the latency, then publish the product.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
            end_cnt  <= '0;
            a_ext    <= '0;
            b_ext    <= '0;
            s        <= '0;
        end else begin
            if (end_cnt != 2'd0) end_cnt <= end_cnt - 1'b1;
            if (start) begin
                a_ext    <= {{TAM{a[TAM-1]}}, a};
                b_ext    <= {{TAM{b[TAM-1]}}, b};
                busy_cnt <= CW'(TAM);
                end_cnt  <= '0;
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - 1'b1;
                if (busy_cnt == CW'(1)) begin
                    s       <= a_ext * b_ext;
                    end_cnt <= 2'd2;
                end
            end
        end
    end

    assign end_mult = (end_cnt != 2'd0);

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NREQ requesters,
// with a timeout abort and a drain state that waits out a lingering end_mult.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int TAM     = DEFAULT_TAM,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*TAM-1:0]   a_in,
    input  logic [NREQ*TAM-1:0]   b_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [NREQ-1:0]       err,
    output logic [2*TAM-1:0]      s_out,
    output logic                  busy
);
    localparam int IW       = $clog2(NREQ);
    localparam int CNTW     = $clog2(TIMEOUT + 1);
    // The START cycle plus the WAIT cycles add up to TIMEOUT, so ERR lands exactly TIMEOUT cycles after START.
    localparam int ABORT_AT = TIMEOUT - 2;

    state_t           state;
    state_t           state_next;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    owner;
    logic [NREQ-1:0]  owner_oh;
    logic [CNTW-1:0]  wait_cnt;
    logic             abort_hold;
    logic [TAM-1:0]   a_lat;
    logic [TAM-1:0]   b_lat;
    logic             pick_any;
    logic [NREQ-1:0]  pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             mult_start;
    logic             mult_rst_n;
    logic             mult_end;
    logic [2*TAM-1:0] mult_s;
    logic             grant_active;

    mult_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req        (req),
        .ptr        (ptr),
        .any        (pick_any),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx)
    );

    multipli #(.TAM(TAM)) u_mult (
        .clock    (clock),
        .rst_n    (mult_rst_n),
        .start    (mult_start),
        .a        (a_lat),
        .b        (b_lat),
        .s        (mult_s),
        .end_mult (mult_end)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; ABORT lasts two cycles to keep the multiplier in reset long enough.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (pick_any) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_WAIT;
            ST_WAIT:  begin
                if (mult_end)                        state_next = ST_DONE;
                else if (wait_cnt == CNTW'(ABORT_AT)) state_next = ST_ABORT;
            end
            ST_DONE:  state_next = ST_DRAIN;
            ST_DRAIN: if (!mult_end) state_next = ST_IDLE;
            ST_ABORT: if (abort_hold) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch the winner and its operands, run the timeout, capture the product, advance the pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            owner      <= '0;
            owner_oh   <= '0;
            wait_cnt   <= '0;
            abort_hold <= 1'b0;
            a_lat      <= '0;
            b_lat      <= '0;
            s_out      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        owner    <= pick_idx;
                        owner_oh <= pick_oh;
                        a_lat    <= a_in[int'(pick_idx)*TAM +: TAM];
                        b_lat    <= b_in[int'(pick_idx)*TAM +: TAM];
                    end
                end
                ST_LOAD: wait_cnt <= '0;
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (mult_end) s_out <= mult_s;
                end
                ST_DONE: ptr <= IW'(wrap_inc(int'(owner), NREQ));
                ST_ABORT: begin
                    abort_hold <= ~abort_hold;
                    if (abort_hold) ptr <= IW'(wrap_inc(int'(owner), NREQ));
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the state and the latched owner.
    always_comb begin
        busy         = (state != ST_IDLE);
        mult_start   = (state == ST_LOAD);
        mult_rst_n   = !(reset || state == ST_ABORT);
        grant_active = (state inside {ST_LOAD, ST_WAIT, ST_DONE, ST_DRAIN}) ||
                       (state == ST_ABORT && !abort_hold);
        gnt          = grant_active ? owner_oh : '0;
        done         = (state == ST_DONE) ? owner_oh : '0;
        err          = (state == ST_ABORT && !abort_hold) ? owner_oh : '0;
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized bench for mult_arbiter with a round-robin / signed-product reference model.
module tb_mult_arbiter;

    localparam int TAM     = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  err;
    logic [15:0] s_out;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int done_pulses = 0;

    // Reference model state: round-robin pointer, last product, per-requester operands.
    int          ptr_m = 0;
    logic [15:0] s_m   = '0;
    int          opa[4];
    int          opb[4];

    always #5 clock = ~clock;

    mult_arbiter #(.TAM(TAM), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .a_in  (a_in),
        .b_in  (b_in),
        .gnt   (gnt),
        .done  (done),
        .err   (err),
        .s_out (s_out),
        .busy  (busy)
    );

    function automatic int model_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [15:0] model_prod(input int a, input int b);
        return 16'(a * b);
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        opa[i] = a;
        opb[i] = b;
        a_in[i*8 +: 8] = 8'(a);
        b_in[i*8 +: 8] = 8'(b);
    endtask

    function automatic int rnd_op();
        return int'($urandom_range(255, 0)) - 128;
    endfunction

    // Waits up to 100 cycles for: 0 grant, 1 done, 2 err, 3 idle.
    task automatic wait_for(input int what, output int idx, output int cycles, output bit ok);
        logic [3:0] v;
        ok = 1'b0; idx = -1; cycles = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            case (what)
                0:       v = gnt;
                1:       v = done;
                2:       v = err;
                default: v = busy ? 4'b0000 : 4'b0001;
            endcase
            if (v != 4'b0000) begin
                ok = 1'b1; idx = oh_idx(v); cycles = c;
                break;
            end
        end
    endtask

    // Continuous one-hot and ownership check plus DONE pulse counting.
    always @(negedge clock) begin
        if (!reset) begin
            vectors++;
            if (!$onehot0(gnt) || !$onehot0(done) || !$onehot0(err) ||
                (done != 0 && done != gnt) || (err != 0 && err != gnt)) begin
                miscompares++;
                $display("[TB] FAIL onehot: gnt=%b done=%b err=%b, required one-hot and owned", gnt, done, err);
            end
            if (done != 0) done_pulses++;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        ptr_m = 0;
        s_m   = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; a_in = '0; b_in = '0;
        for (int i = 0; i < 4; i++) begin opa[i] = 0; opb[i] = 0; end
        repeat (3) @(negedge clock);
        vectors++;
        if (gnt !== 4'b0 || done !== 4'b0 || err !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_handshake: gnt=%b done=%b err=%b, required 0000", gnt, done, err);
        end
        vectors++;
        if (s_out !== 16'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: s_out=%h busy=%b, required 0000/0", s_out, busy);
        end
        reset = 1'b0; ptr_m = 0; s_m = '0;
    endtask

    task automatic test_single();
        int idx, cyc, d0, exp;
        bit ok;
        set_op(1, 3, 5);
        req = 4'b0010;
        exp = model_pick(req, ptr_m);
        wait_for(0, idx, cyc, ok);
        vectors++;
        if (idx != exp || cyc != 1) begin
            miscompares++;
            $display("[TB] FAIL single_grant: idx=%0d after %0d cycles, required idx=%0d after 1", idx, cyc, exp);
        end
        req = 4'b0000;
        d0 = done_pulses;
        wait_for(1, idx, cyc, ok);
        vectors++;
        if (idx != exp || s_out !== model_prod(3, 5)) begin
            miscompares++;
            $display("[TB] FAIL single_done: idx=%0d s_out=%0d, required idx=%0d s_out=%0d",
                     idx, $signed(s_out), exp, $signed(model_prod(3, 5)));
        end
        ptr_m = (exp + 1) % 4; s_m = model_prod(3, 5);
        wait_for(3, idx, cyc, ok);
        vectors++;
        if (!ok || done_pulses - d0 != 1) begin
            miscompares++;
            $display("[TB] FAIL single_idle: idle=%0d pulses=%0d, required idle=1 pulses=1", ok, done_pulses - d0);
        end
    endtask

    task automatic test_round_robin();
        int idx, cyc, exp;
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, -(i + 1), 10);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp = model_pick(req, ptr_m);
            wait_for(1, idx, cyc, ok);
            if (n == 4) req = 4'b0000;
            vectors++;
            if (idx != exp || s_out !== model_prod(opa[exp], opb[exp])) begin
                miscompares++;
                $display("[TB] FAIL rr_%0d: idx=%0d s_out=%0d, required idx=%0d s_out=%0d",
                         n, idx, $signed(s_out), exp, $signed(model_prod(opa[exp], opb[exp])));
            end
            ptr_m = (exp + 1) % 4; s_m = model_prod(opa[exp], opb[exp]);
        end
        wait_for(3, idx, cyc, ok);
    endtask

    task automatic test_wrap();
        int idx, cyc, exp;
        bit ok;
        do_reset();
        set_op(2, rnd_op(), rnd_op());
        req = 4'b0100;
        wait_for(0, idx, cyc, ok);
        req = 4'b0000;
        wait_for(1, idx, cyc, ok);
        vectors++;
        if (idx != 2 || s_out !== model_prod(opa[2], opb[2])) begin
            miscompares++;
            $display("[TB] FAIL wrap_pre: idx=%0d s_out=%0d, required idx=2 s_out=%0d",
                     idx, $signed(s_out), $signed(model_prod(opa[2], opb[2])));
        end
        ptr_m = 3; s_m = model_prod(opa[2], opb[2]);
        wait_for(3, idx, cyc, ok);
        set_op(3, rnd_op(), rnd_op());
        set_op(0, rnd_op(), rnd_op());
        req = 4'b1001;
        for (int n = 0; n < 2; n++) begin
            exp = model_pick(req, ptr_m);
            wait_for(1, idx, cyc, ok);
            if (n == 1) req = 4'b0000;
            vectors++;
            if (idx != exp || s_out !== model_prod(opa[exp], opb[exp])) begin
                miscompares++;
                $display("[TB] FAIL wrap_%0d: idx=%0d s_out=%0d, required idx=%0d s_out=%0d",
                         n, idx, $signed(s_out), exp, $signed(model_prod(opa[exp], opb[exp])));
            end
            ptr_m = (exp + 1) % 4; s_m = model_prod(opa[exp], opb[exp]);
        end
        wait_for(3, idx, cyc, ok);
    endtask

    task automatic test_extremes();
        int ea[3] = '{-128, -1, 0};
        int eb[3] = '{-128, 2, 0};
        int es[3] = '{16384, -2, 0};
        int idx, cyc, r;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            r = int'($urandom_range(3, 0));
            set_op(r, ea[k], eb[k]);
            req = 4'(1 << r);
            wait_for(0, idx, cyc, ok);
            req = 4'b0000;
            wait_for(1, idx, cyc, ok);
            vectors++;
            if (idx != r || s_out !== 16'(es[k])) begin
                miscompares++;
                $display("[TB] FAIL extreme_%0d: idx=%0d s_out=%0d, required idx=%0d s_out=%0d",
                         k, idx, $signed(s_out), r, es[k]);
            end
            ptr_m = (r + 1) % 4; s_m = 16'(es[k]);
            wait_for(3, idx, cyc, ok);
        end
    endtask

    task automatic test_timeout();
        int idx, cyc, r, d0;
        bit ok;
        force dut.mult_end = 1'b0;
        r = int'($urandom_range(3, 0));
        set_op(r, rnd_op(), rnd_op());
        req = 4'(1 << r);
        d0 = done_pulses;
        wait_for(0, idx, cyc, ok);
        req = 4'b0000;
        wait_for(2, idx, cyc, ok);
        vectors++;
        if (idx != r || cyc != TIMEOUT) begin
            miscompares++;
            $display("[TB] FAIL timeout_err: idx=%0d at %0d cycles after START, required idx=%0d at %0d",
                     idx, cyc, r, TIMEOUT);
        end
        vectors++;
        if (s_out !== s_m || done_pulses != d0) begin
            miscompares++;
            $display("[TB] FAIL timeout_data: s_out=%0d pulses=%0d, required s_out=%0d pulses=0",
                     $signed(s_out), done_pulses - d0, $signed(s_m));
        end
        ptr_m = (r + 1) % 4;
        wait_for(3, idx, cyc, ok);
        release dut.mult_end;
        r = int'($urandom_range(3, 0));
        set_op(r, rnd_op(), rnd_op());
        req = 4'(1 << r);
        wait_for(0, idx, cyc, ok);
        req = 4'b0000;
        wait_for(1, idx, cyc, ok);
        vectors++;
        if (idx != r || s_out !== model_prod(opa[r], opb[r])) begin
            miscompares++;
            $display("[TB] FAIL timeout_recover: idx=%0d s_out=%0d, required idx=%0d s_out=%0d",
                     idx, $signed(s_out), r, $signed(model_prod(opa[r], opb[r])));
        end
        ptr_m = (r + 1) % 4; s_m = model_prod(opa[r], opb[r]);
        wait_for(3, idx, cyc, ok);
    endtask

    task automatic test_reset_mid();
        int idx, cyc, r, d0;
        bit ok;
        r = int'($urandom_range(3, 0));
        set_op(r, rnd_op(), rnd_op());
        req = 4'(1 << r);
        wait_for(0, idx, cyc, ok);
        req = 4'b0000;
        repeat (3) @(negedge clock);
        d0 = done_pulses;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (gnt !== 4'b0 || done !== 4'b0 || err !== 4'b0 || busy !== 1'b0 || s_out !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: gnt=%b done=%b err=%b busy=%b s_out=%h, required all zero",
                     gnt, done, err, busy, s_out);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0; ptr_m = 0; s_m = '0;
        repeat (15) @(negedge clock);
        vectors++;
        if (done_pulses != d0) begin
            miscompares++;
            $display("[TB] FAIL midreset_nodone: pulses=%0d, required 0", done_pulses - d0);
        end
        r = int'($urandom_range(3, 0));
        set_op(r, 7, -6);
        req = 4'(1 << r);
        wait_for(0, idx, cyc, ok);
        req = 4'b0000;
        wait_for(1, idx, cyc, ok);
        vectors++;
        if (idx != r || s_out !== 16'(-42)) begin
            miscompares++;
            $display("[TB] FAIL midreset_next: idx=%0d s_out=%0d, required idx=%0d s_out=-42", idx, $signed(s_out), r);
        end
        ptr_m = (r + 1) % 4; s_m = 16'(-42);
        wait_for(3, idx, cyc, ok);
    endtask

    task automatic test_random();
        int idx, cyc, exp, ea, eb;
        bit ok;
        logic [3:0] r;
        for (int n = 0; n < 20; n++) begin
            r = 4'($urandom_range(15, 1));
            for (int i = 0; i < 4; i++) set_op(i, rnd_op(), rnd_op());
            req = r;
            exp = model_pick(r, ptr_m);
            ea = opa[exp]; eb = opb[exp];
            wait_for(0, idx, cyc, ok);
            a_in = $urandom;
            b_in = $urandom;
            vectors++;
            if (idx != exp) begin
                miscompares++;
                $display("[TB] FAIL rand_grant_%0d: idx=%0d, required %0d (req=%b ptr=%0d)", n, idx, exp, r, ptr_m);
            end
            wait_for(1, idx, cyc, ok);
            req = 4'b0000;
            vectors++;
            if (idx != exp || s_out !== model_prod(ea, eb)) begin
                miscompares++;
                $display("[TB] FAIL rand_done_%0d: idx=%0d s_out=%0d, required idx=%0d s_out=%0d",
                         n, idx, $signed(s_out), exp, $signed(model_prod(ea, eb)));
            end
            ptr_m = (exp + 1) % 4; s_m = model_prod(ea, eb);
            wait_for(3, idx, cyc, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("[TB] FAIL rand_idle_%0d: busy=%b, required 0 within 100 cycles", n, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_extremes();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "[TB] global time limit expired");
    end

endmodule
